// File: rtl/spi_parallel_pkg.sv
// Shared types and helpers for the parallel-lane SPI shift engine.
package spi_parallel_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StDone
    } state_e;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned FRAME_LEN_W        = $clog2(DEFAULT_DATA_WIDTH);

    // LSB position of a lane's word inside a packed multi-lane bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/spi_parallel_engine_sclk_gen.sv
// SCLK divider: one strobe every clk_div+1 clocks while enabled, SCLK toggles on
// strobes when toggling is allowed, and each strobe is classed as leading or trailing.
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     toggle_en,
    input  logic [CLK_DIV_WIDTH-1:0] clk_div,
    input  logic                     idle_level,
    output logic                     tick,
    output logic                     lead_stb,
    output logic                     trail_stb,
    output logic                     spi_sclk
);

    logic [CLK_DIV_WIDTH-1:0] cnt_q;
    logic                     run_q;
    logic                     sclk_q;

    // run_q delays counting by one clock, giving CS_N one extra clock of setup.
    assign tick      = enable && run_q && (cnt_q == '0);
    assign lead_stb  = tick && toggle_en && (sclk_q == idle_level);
    assign trail_stb = tick && toggle_en && (sclk_q != idle_level);
    assign spi_sclk  = sclk_q;

    // Divider counter reload/decrement and SCLK level.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            sclk_q <= 1'b0;
        end else begin
            run_q <= enable;
            if (!(enable && run_q) || tick) begin
                cnt_q <= clk_div;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (!enable) begin
                sclk_q <= idle_level;
            end else if (tick && toggle_en) begin
                sclk_q <= ~sclk_q;
            end
        end
    end

endmodule

// File: rtl/spi_parallel_engine.sv
// Multi-lane SPI master: one CS_N-framed, MSB-first transfer per command on all lanes,
// sharing a single SCLK and CS_N.
module spi_parallel_engine
    import spi_parallel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned CLK_DIV_WIDTH = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [CLK_DIV_WIDTH-1:0]          cfg_clk_div,
    input  logic                              cfg_cpol,
    input  logic                              cfg_cpha,
    input  logic [$clog2(DATA_WIDTH)-1:0]     cfg_frame_len,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]   cmd_tx_data,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [DATA_WIDTH*NUM_LANES-1:0]   rsp_rx_data,
    output logic                              spi_sclk,
    output logic                              spi_cs_n,
    output logic [NUM_LANES-1:0]              spi_mosi,
    input  logic [NUM_LANES-1:0]              spi_miso
);

    localparam int unsigned FrameLenW = $clog2(DATA_WIDTH);
    localparam int unsigned EdgeW     = FrameLenW + 2;
    localparam logic [FrameLenW:0] MaxLen = (FrameLenW + 1)'(DATA_WIDTH - 1);

    state_e                   state_q;
    logic [CLK_DIV_WIDTH-1:0] div_q;
    logic                     cpol_q;
    logic                     cpha_q;
    logic [EdgeW-1:0]         edge_cnt_q;

    logic [FrameLenW-1:0]     len_clamped;
    logic [FrameLenW-1:0]     shamt;
    logic                     accept;
    logic                     tick;
    logic                     lead_stb;
    logic                     trail_stb;
    logic                     last_edge;
    logic                     shift_edge;
    logic                     sample_edge;
    logic                     gen_enable;
    logic                     gen_toggle;
    logic [CLK_DIV_WIDTH-1:0] gen_div;
    logic                     gen_idle_level;

    assign accept      = (state_q == StIdle) && cmd_valid;
    assign last_edge   = (edge_cnt_q == EdgeW'(1));
    // CPHA=0 has no bit left to drive on the final trailing edge, so MOSI holds.
    assign shift_edge  = cpha_q ? lead_stb : (trail_stb && !last_edge);
    assign sample_edge = cpha_q ? trail_stb : lead_stb;

    // Divider follows live config in IDLE so it is already loaded at the accept edge.
    assign gen_enable     = (state_q == StSetup) || (state_q == StShift) || (state_q == StHold);
    assign gen_toggle     = (state_q == StShift);
    assign gen_div        = (state_q == StIdle) ? cfg_clk_div : div_q;
    assign gen_idle_level = (state_q == StIdle) ? cfg_cpol : cpol_q;

    // Clamp the frame length and derive the left-align shift that puts bit L at the MSB.
    always_comb begin
        len_clamped = cfg_frame_len;
        if ({1'b0, cfg_frame_len} > MaxLen) begin
            len_clamped = MaxLen[FrameLenW-1:0];
        end
        shamt = MaxLen[FrameLenW-1:0] - len_clamped;
    end

    spi_sclk_gen #(
        .CLK_DIV_WIDTH (CLK_DIV_WIDTH)
    ) u_sclk_gen (
        .clock      (clock),
        .reset      (reset),
        .enable     (gen_enable),
        .toggle_en  (gen_toggle),
        .clk_div    (gen_div),
        .idle_level (gen_idle_level),
        .tick       (tick),
        .lead_stb   (lead_stb),
        .trail_stb  (trail_stb),
        .spi_sclk   (spi_sclk)
    );

    // Frame FSM with registered handshake and chip-select outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            spi_cs_n   <= 1'b1;
            div_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        state_q    <= StSetup;
                        cmd_ready  <= 1'b0;
                        spi_cs_n   <= 1'b0;
                        div_q      <= cfg_clk_div;
                        cpol_q     <= cfg_cpol;
                        cpha_q     <= cfg_cpha;
                        edge_cnt_q <= {1'b0, len_clamped, 1'b0} + EdgeW'(2);
                    end
                end
                StSetup: begin
                    if (tick) begin
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (tick) begin
                        edge_cnt_q <= edge_cnt_q - 1'b1;
                        if (last_edge) begin
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (tick) begin
                        state_q   <= StDone;
                        spi_cs_n  <= 1'b1;
                        rsp_valid <= 1'b1;
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        state_q   <= StIdle;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    spi_cs_n  <= 1'b1;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [DATA_WIDTH-1:0] tx_word;
        logic [DATA_WIDTH-1:0] aligned;
        logic [DATA_WIDTH-1:0] tx_q;
        logic [DATA_WIDTH-1:0] rx_q;
        logic                  mosi_q;

        assign tx_word = cmd_tx_data[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
        assign aligned = tx_word << shamt;

        assign spi_mosi[k]                                     = mosi_q;
        assign rsp_rx_data[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = rx_q;

        // Per-lane tx/rx shift registers; CPHA=0 presents bit L from the accept edge.
        always_ff @(posedge clock) begin
            if (reset) begin
                tx_q   <= '0;
                rx_q   <= '0;
                mosi_q <= 1'b0;
            end else if (accept) begin
                rx_q <= '0;
                if (!cfg_cpha) begin
                    mosi_q <= aligned[DATA_WIDTH-1];
                    tx_q   <= aligned << 1;
                end else begin
                    tx_q <= aligned;
                end
            end else if (state_q == StShift) begin
                if (shift_edge) begin
                    mosi_q <= tx_q[DATA_WIDTH-1];
                    tx_q   <= tx_q << 1;
                end
                if (sample_edge) begin
                    rx_q <= {rx_q[DATA_WIDTH-2:0], spi_miso[k]};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_parallel_engine.sv
// Self-checking bench: an SPI slave model on every lane plus frame-level expectations.
module tb_spi_parallel_engine;

    localparam int DW = 32;
    localparam int NL = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [7:0]      cfg_clk_div = '0;
    logic            cfg_cpol = 1'b0;
    logic            cfg_cpha = 1'b0;
    logic [4:0]      cfg_frame_len = '0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [DW*NL-1:0] cmd_tx_data = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [DW*NL-1:0] rsp_rx_data;
    logic            spi_sclk;
    logic            spi_cs_n;
    logic [NL-1:0]   spi_mosi;
    logic [NL-1:0]   spi_miso;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame parameters as the DUT should have captured them, and slave-side state.
    logic [31:0] tx_w [NL];
    logic [31:0] s_word [NL];
    logic [31:0] mosi_cap [NL];
    logic        f_cpol = 1'b0;
    logic        f_cpha = 1'b0;
    logic        f_lb = 1'b1;
    int          f_len = 0;
    int          f_div = 0;
    int          cyc = 0;
    int          last_tog = 0;
    int          ntog = 0;
    int          rises = 0;
    int          nsamp = 0;
    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b0;

    spi_parallel_engine #(
        .DATA_WIDTH    (DW),
        .NUM_LANES     (NL),
        .CLK_DIV_WIDTH (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cfg_clk_div   (cfg_clk_div),
        .cfg_cpol      (cfg_cpol),
        .cfg_cpha      (cfg_cpha),
        .cfg_frame_len (cfg_frame_len),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_tx_data   (cmd_tx_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rx_data   (rsp_rx_data),
        .spi_sclk      (spi_sclk),
        .spi_cs_n      (spi_cs_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model: presents bit (L - samples taken) of its word, or loops MOSI back.
    always_comb begin
        spi_miso = '0;
        for (int k = 0; k < NL; k++) begin
            if (f_lb) begin
                spi_miso[k] = spi_mosi[k];
            end else if (nsamp <= f_len) begin
                spi_miso[k] = s_word[k][f_len - nsamp];
            end
        end
    end

    // Bus monitor: SCLK half-period, rising-edge count, MOSI capture on sample edges.
    always @(negedge clock) begin
        cyc++;
        if (!spi_cs_n && cs_prev) begin
            ntog  = 0;
            rises = 0;
            nsamp = 0;
            for (int k = 0; k < NL; k++) mosi_cap[k] = '0;
        end else if (!spi_cs_n && (spi_sclk !== sclk_prev)) begin
            ntog++;
            if (spi_sclk) rises++;
            if (ntog > 1) check_eq("sclk_half_period", cyc - last_tog, f_div + 1);
            last_tog = cyc;
            if ((sclk_prev == f_cpol) != f_cpha) begin
                for (int k = 0; k < NL; k++) mosi_cap[k] = {mosi_cap[k][30:0], spi_mosi[k]};
                nsamp++;
            end
        end
        cs_prev   = spi_cs_n;
        sclk_prev = spi_sclk;
    end

    task automatic start_frame(input logic cpol, input logic cpha, input int len, input int div,
                               input logic lb, input logic early, input logic scramble,
                               input logic hold);
        @(negedge clock);
        check_eq("cmd_ready_before_accept", cmd_ready, 1);
        f_cpol = cpol;
        f_cpha = cpha;
        f_len  = len;
        f_div  = div;
        f_lb   = lb;
        cfg_cpol      = cpol;
        cfg_cpha      = cpha;
        cfg_frame_len = 5'(len);
        cfg_clk_div   = 8'(div);
        for (int k = 0; k < NL; k++) cmd_tx_data[k*DW +: DW] = tx_w[k];
        cmd_valid = 1'b1;
        rsp_ready = early;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = hold;
        if (scramble) begin
            cfg_cpol      = 1'($urandom_range(0, 1));
            cfg_cpha      = 1'($urandom_range(0, 1));
            cfg_frame_len = 5'($urandom_range(0, 31));
            cfg_clk_div   = 8'($urandom_range(0, 255));
            for (int k = 0; k < NL; k++) cmd_tx_data[k*DW +: DW] = $urandom;
        end
        check_eq("cs_n_low_after_accept", spi_cs_n, 0);
    endtask

    // Called at the first negedge after the accept edge.
    task automatic finish_frame();
        int          lat;
        logic [31:0] mask;
        logic [31:0] exp;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 5000) begin
            @(negedge clock);
            lat++;
        end
        check_eq("latency", lat, (2 * (f_len + 1) + 2) * (f_div + 1) + 1);
        mask = 32'hFFFF_FFFF >> (31 - f_len);
        for (int k = 0; k < NL; k++) begin
            exp = (f_lb ? tx_w[k] : s_word[k]) & mask;
            check_eq($sformatf("rx_lane%0d", k), rsp_rx_data[k*DW +: DW], exp);
            check_eq($sformatf("mosi_lane%0d", k), mosi_cap[k], tx_w[k] & mask);
        end
        check_eq("sclk_rising_edges", rises, f_len + 1);
        check_eq("cs_n_high_in_done", spi_cs_n, 1);
        check_eq("cmd_ready_in_done", cmd_ready, 0);
        check_eq("sclk_idle_level", spi_sclk, f_cpol);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clock);
        check_eq("rsp_valid_after_handshake", rsp_valid, 0);
        check_eq("cmd_ready_after_handshake", cmd_ready, 1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int w;
        int seen;
        logic [31:0] hold_exp;

        repeat (3) @(negedge clock);
        check_eq("reset_cmd_ready", cmd_ready, 1);
        check_eq("reset_rsp_valid", rsp_valid, 0);
        check_eq("reset_rx_zero", |rsp_rx_data, 0);
        check_eq("reset_cs_n", spi_cs_n, 1);
        check_eq("reset_sclk", spi_sclk, 0);
        check_eq("reset_mosi", spi_mosi, 0);
        reset = 1'b0;

        // 1: loopback, H=1, mode 0, 8 bits
        tx_w = '{32'hA5, 32'h3C, 32'h00, 32'hFF};
        start_frame(1'b0, 1'b0, 7, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_frame();
        handshake();

        // 2: all four SPI modes, 16-bit loopback
        for (int m = 0; m < 4; m++) begin
            tx_w = '{32'h1234, 32'hBEEF, 32'h8001, 32'h7FFE};
            start_frame(1'(m >> 1), 1'(m), 15, 0, 1'b1, 1'b0, 1'b0, 1'b0);
            finish_frame();
            handshake();
        end

        // 3: four lanes against slave words
        tx_w   = '{32'h11, 32'h22, 32'h44, 32'h88};
        s_word = '{32'h3C, 32'hC3, 32'h5A, 32'h96};
        start_frame(1'b0, 1'b0, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_frame();
        handshake();

        // 4: single-bit frame with H=4
        for (int k = 0; k < NL; k++) s_word[k] = $urandom;
        start_frame(1'b0, 1'b0, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_frame();
        handshake();

        // 5: reset in the middle of SHIFT, then a clean frame
        tx_w = '{32'hDEAD, 32'hBEEF, 32'hCAFE, 32'hF00D};
        start_frame(1'b0, 1'b0, 15, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        w = 0;
        while (ntog < 5 && w < 500) begin
            @(negedge clock);
            w++;
        end
        check_eq("reached_fifth_edge", ntog >= 5, 1);
        reset = 1'b1;
        @(negedge clock);
        check_eq("abort_cs_n", spi_cs_n, 1);
        check_eq("abort_sclk", spi_sclk, 0);
        check_eq("abort_idle", cmd_ready, 1);
        check_eq("abort_no_rsp", rsp_valid, 0);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (rsp_valid) seen++;
        end
        check_eq("no_rsp_after_abort", seen, 0);
        start_frame(1'b1, 1'b0, 15, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_frame();
        handshake();

        // 6: response held off, cmd_valid held high, back-to-back restart
        for (int k = 0; k < NL; k++) begin
            tx_w[k]   = $urandom;
            s_word[k] = $urandom;
        end
        start_frame(1'b1, 1'b1, 7, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        finish_frame();
        hold_exp = s_word[0] & 32'hFF;
        repeat (10) begin
            @(negedge clock);
            check_eq("hold_rsp_valid", rsp_valid, 1);
            check_eq("hold_cmd_ready", cmd_ready, 0);
            check_eq("hold_rx_lane0", rsp_rx_data[DW-1:0], hold_exp);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check_eq("b2b_idle_cs_n", spi_cs_n, 1);
        check_eq("b2b_idle_ready", cmd_ready, 1);
        @(negedge clock);
        check_eq("b2b_next_cs_n", spi_cs_n, 0);
        check_eq("b2b_next_busy", cmd_ready, 0);
        cmd_valid = 1'b0;
        finish_frame();
        handshake();

        // Randomized frames: mode, length, divider, data, early ready, config scrambling
        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < NL; k++) begin
                tx_w[k]   = $urandom;
                s_word[k] = $urandom;
            end
            start_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 31), $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'b0);
            finish_frame();
            handshake();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
